// File: rtl/axis_join_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axis_join_pkg
//  Purpose  : Shared types and helpers for the N-way vector stream join.
//             Default vector geometry, the vector beat type, and the FIFO
//             pointer-width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package axis_join_pkg;

   localparam int unsigned c_tile_size  = 4;
   localparam int unsigned c_data_width = 16;

   typedef logic [c_tile_size-1:0][c_data_width-1:0] vec_t;

   // Pointer width for a power-of-two ring of the given depth.
   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage
`default_nettype wire

// File: rtl/vec_ring_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : vec_ring_fifo
//  Purpose  : Single-channel ring FIFO for one vector stream.
//  Ports    : clk, rst    - clock, synchronous active-high reset
//             flush       - synchronous clear, wins over push/pop
//             push, din   - write strobe and data (caller guarantees not full)
//             pop         - advance head (caller guarantees not empty)
//             count       - registered occupancy 0..DEPTH
//             head        - storage word at the read pointer
//  Revision : 1.0 - initial release
// ============================================================================
module vec_ring_fifo
   import axis_join_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [$clog2(DEPTH):0]     count,
   output logic [WIDTH-1:0]           head
);

   localparam int unsigned PTR_W = ptr_w(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr;
   logic [PTR_W-1:0] r_rd;
   logic [CNT_W-1:0] r_count;

   // Pointers wrap on their own because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (push) r_wr <= r_wr + PTR_W'(1);
         if (pop)  r_rd <= r_rd + PTR_W'(1);
         r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage is not reset; a write during clear would land behind the
   // rewound pointer anyway, but it is suppressed to keep intent obvious.
   always_ff @(posedge clk) begin
      if (push && !flush && !rst) r_mem[r_wr] <= din;
   end

   assign count = r_count;
   assign head  = r_mem[r_rd];

endmodule
`default_nettype wire

// File: rtl/axis_vec_joinn.sv
`default_nettype none
// ============================================================================
//  Module   : axis_vec_joinn
//  Purpose  : Joins NUM_CH valid/ready vector streams into one aligned beat.
//             Each channel is buffered in its own ring FIFO; a per-channel
//             reuse count holds a slow operand at its FIFO head for
//             cfg_reuse+1 joins before it is popped.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             in_valid/ready/vec - per-channel input streams
//             cfg_reuse         - per-channel head reuse count (quasi-static)
//             flush             - synchronous clear of all channels
//             out_valid/ready/vec - joined output stream
//             out_first         - every head is on its first use
//             level             - per-channel occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module axis_vec_joinn
   import axis_join_pkg::*;
#(
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned TILE_SIZE  = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned REUSE_W    = 4
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic [NUM_CH-1:0]                                in_valid,
   output logic [NUM_CH-1:0]                                in_ready,
   input  logic [NUM_CH-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] in_vec,
   input  logic [NUM_CH-1:0][REUSE_W-1:0]                   cfg_reuse,
   input  logic                                             flush,
   output logic                                             out_valid,
   input  logic                                             out_ready,
   output logic [NUM_CH-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] out_vec,
   output logic                                             out_first,
   output logic [NUM_CH-1:0][$clog2(DEPTH):0]               level
);

   localparam int unsigned          LVL_W   = ptr_w(DEPTH) + 1;
   localparam int unsigned          VEC_W   = TILE_SIZE * DATA_WIDTH;
   localparam logic [LVL_W-1:0]     c_depth = LVL_W'(DEPTH);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("axis_vec_joinn: DEPTH must be a power of two >= 2");
   end

   logic [NUM_CH-1:0]              w_nonempty;
   logic [NUM_CH-1:0]              w_push;
   logic [NUM_CH-1:0]              w_pop;
   logic [NUM_CH-1:0]              w_use_zero;
   logic [NUM_CH-1:0][LVL_W-1:0]   w_count;
   logic [NUM_CH-1:0][REUSE_W-1:0] r_use;
   logic                           w_join;

   // A clear cycle never presents a beat downstream, so the join cannot
   // fire while the FIFOs are being discarded.
   assign out_valid = (&w_nonempty) & ~flush & ~rst;
   assign w_join    = out_valid & out_ready;
   assign out_first = &w_use_zero;
   assign level     = w_count;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign in_ready[c]   = (w_count[c] < c_depth);
      assign w_push[c]     = in_valid[c] & in_ready[c];
      assign w_nonempty[c] = (w_count[c] != '0);
      assign w_use_zero[c] = (r_use[c] == '0);
      // >= rather than == so a reuse count lowered below the current use
      // count still releases the head instead of wrapping the counter.
      assign w_pop[c]      = w_join & (r_use[c] >= cfg_reuse[c]);

      always_ff @(posedge clk) begin
         if (rst || flush) begin
            r_use[c] <= '0;
         end else if (w_join) begin
            if (w_pop[c]) r_use[c] <= '0;
            else          r_use[c] <= r_use[c] + REUSE_W'(1);
         end
      end

      vec_ring_fifo #(
         .DEPTH (DEPTH),
         .WIDTH (VEC_W)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .flush (flush),
         .push  (w_push[c]),
         .din   (in_vec[c]),
         .pop   (w_pop[c]),
         .count (w_count[c]),
         .head  (out_vec[c])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_axis_vec_joinn.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_vec_joinn
//  Purpose  : Self-checking bench for axis_vec_joinn (3 channels, depth 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_vec_joinn;

   localparam int NCH = 3;
   localparam int DEP = 4;

   typedef logic [3:0][15:0] vec4_t;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NCH-1:0]           in_valid;
   logic [NCH-1:0]           in_ready;
   logic [NCH-1:0][3:0][15:0] in_vec;
   logic [NCH-1:0][3:0]      cfg_reuse;
   logic                     flush;
   logic                     out_valid;
   logic                     out_ready;
   logic [NCH-1:0][3:0][15:0] out_vec;
   logic                     out_first;
   logic [NCH-1:0][2:0]      level;

   int checks   = 0;
   int failures = 0;

   axis_vec_joinn #(
      .NUM_CH     (NCH),
      .TILE_SIZE  (4),
      .DATA_WIDTH (16),
      .DEPTH      (DEP),
      .REUSE_W    (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .cfg_reuse (cfg_reuse),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_vec   (out_vec),
      .out_first (out_first),
      .level     (level)
   );

   always #5 clk = ~clk;

   // ---------------- reference model: queues + use counts ----------------
   vec4_t mq [NCH][$];
   int    muse [NCH];

   function automatic vec4_t mkvec(input int b);
      vec4_t v;
      for (int e = 0; e < 4; e++) v[e] = 16'(b + e);
      return v;
   endfunction

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      logic ev;
      logic ef;
      ev = !rst && !flush;
      ef = 1'b1;
      for (int c = 0; c < NCH; c++) begin
         if (mq[c].size() == 0) ev = 1'b0;
         if (muse[c] != 0) ef = 1'b0;
      end
      chk("m_out_valid", out_valid, ev);
      chk("m_out_first", out_first, ef);
      for (int c = 0; c < NCH; c++) begin
         chk("m_in_ready", in_ready[c], mq[c].size() < DEP);
         chk("m_level", level[c], mq[c].size());
         if (ev) chk("m_out_vec", out_vec[c], mq[c][0]);
      end
   endtask

   task automatic model_update();
      logic j;
      logic rdy [NCH];
      if (rst || flush) begin
         for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            muse[c] = 0;
         end
      end else begin
         j = out_ready;
         for (int c = 0; c < NCH; c++) begin
            if (mq[c].size() == 0) j = 1'b0;
            rdy[c] = mq[c].size() < DEP;
         end
         for (int c = 0; c < NCH; c++) begin
            if (j) begin
               if (muse[c] >= int'(cfg_reuse[c])) begin
                  void'(mq[c].pop_front());
                  muse[c] = 0;
               end else begin
                  muse[c]++;
               end
            end
            if (in_valid[c] && rdy[c]) mq[c].push_back(in_vec[c]);
         end
      end
   endtask

   task automatic finish_cycle();
      model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic step();
      @(negedge clk);
      finish_cycle();
   endtask

   task automatic set_in(input logic [2:0] iv, input int b0, input int b1, input int b2);
      in_valid  = iv;
      in_vec[0] = mkvec(b0);
      in_vec[1] = mkvec(b1);
      in_vec[2] = mkvec(b2);
   endtask

   // ---------------- table of directed vectors ----------------
   typedef struct {
      logic       fl;
      logic [2:0] iv;
      int         b0, b1, b2;
      logic       ordy;
      logic       e_valid;
      logic [2:0] e_ready;
      logic       e_first;
      int         l0, l1, l2;
      int         e0, e1, e2;
   } vec_rec_t;

   vec_rec_t tbl [14];

   initial begin
      tbl[0]  = '{0, 3'b111,  1,  2,  3, 1, 0, 3'b111, 1, 0, 0, 0,  0,  0,  0};
      tbl[1]  = '{0, 3'b000,  0,  0,  0, 1, 1, 3'b111, 1, 1, 1, 1,  1,  2,  3};
      tbl[2]  = '{0, 3'b000,  0,  0,  0, 1, 0, 3'b111, 1, 0, 0, 0,  0,  0,  0};
      tbl[3]  = '{0, 3'b001, 10,  0,  0, 1, 0, 3'b111, 1, 0, 0, 0,  0,  0,  0};
      tbl[4]  = '{0, 3'b001, 11,  0,  0, 1, 0, 3'b111, 1, 1, 0, 0,  0,  0,  0};
      tbl[5]  = '{0, 3'b001, 12,  0,  0, 1, 0, 3'b111, 1, 2, 0, 0,  0,  0,  0};
      tbl[6]  = '{0, 3'b001, 13,  0,  0, 1, 0, 3'b111, 1, 3, 0, 0,  0,  0,  0};
      tbl[7]  = '{0, 3'b001, 14,  0,  0, 1, 0, 3'b110, 1, 4, 0, 0,  0,  0,  0};
      tbl[8]  = '{0, 3'b110,  0, 20, 30, 1, 0, 3'b110, 1, 4, 0, 0,  0,  0,  0};
      tbl[9]  = '{0, 3'b110,  0, 21, 31, 1, 1, 3'b110, 1, 4, 1, 1, 10, 20, 30};
      tbl[10] = '{0, 3'b110,  0, 22, 32, 1, 1, 3'b111, 1, 3, 1, 1, 11, 21, 31};
      tbl[11] = '{0, 3'b110,  0, 23, 33, 1, 1, 3'b111, 1, 2, 1, 1, 12, 22, 32};
      tbl[12] = '{0, 3'b000,  0,  0,  0, 1, 1, 3'b111, 1, 1, 1, 1, 13, 23, 33};
      tbl[13] = '{0, 3'b000,  0,  0,  0, 1, 0, 3'b111, 1, 0, 0, 0,  0,  0,  0};
   end

   // ---------------- main sequence ----------------
   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = '0;
      in_vec    = '0;
      cfg_reuse = '0;
      out_ready = 1'b0;
      for (int c = 0; c < NCH; c++) muse[c] = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed table: reset state, single join, fill-to-full, drain order.
      for (int i = 0; i < 14; i++) begin
         flush     = tbl[i].fl;
         out_ready = tbl[i].ordy;
         set_in(tbl[i].iv, tbl[i].b0, tbl[i].b1, tbl[i].b2);
         @(negedge clk);
         chk("t_out_valid", out_valid, tbl[i].e_valid);
         chk("t_in_ready",  in_ready,  tbl[i].e_ready);
         chk("t_out_first", out_first, tbl[i].e_first);
         chk("t_level0", level[0], tbl[i].l0);
         chk("t_level1", level[1], tbl[i].l1);
         chk("t_level2", level[2], tbl[i].l2);
         if (tbl[i].e_valid) begin
            chk("t_vec0", out_vec[0], mkvec(tbl[i].e0));
            chk("t_vec1", out_vec[1], mkvec(tbl[i].e1));
            chk("t_vec2", out_vec[2], mkvec(tbl[i].e2));
         end
         finish_cycle();
      end

      // Reuse: one lambda beat joined with four x beats.
      cfg_reuse = '{4'd0, 4'd0, 4'd3};
      out_ready = 1'b1;
      set_in(3'b111, 100, 200, 300);
      step();
      for (int k = 1; k <= 4; k++) begin
         if (k < 4) set_in(3'b110, 0, 200 + k, 300 + k);
         else       set_in(3'b000, 0, 0, 0);
         @(negedge clk);
         chk("r_valid", out_valid, 1'b1);
         chk("r_first", out_first, k == 1);
         chk("r_lambda", out_vec[0], mkvec(100));
         chk("r_x", out_vec[1], mkvec(200 + k - 1));
         finish_cycle();
      end
      set_in(3'b000, 0, 0, 0);
      @(negedge clk);
      chk("r_level0_after", level[0], 0);
      finish_cycle();

      // Full with downstream stalled, then steady throughput at DEPTH-1.
      cfg_reuse = '0;
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         set_in(3'b111, 400 + k, 500 + k, 600 + k);
         step();
      end
      set_in(3'b000, 0, 0, 0);
      step();
      step();
      out_ready = 1'b1;
      set_in(3'b111, 410, 510, 610);
      step();
      for (int k = 1; k < 7; k++) begin
         set_in(3'b111, 410 + k, 510 + k, 610 + k);
         @(negedge clk);
         chk("thr_valid", out_valid, 1'b1);
         chk("thr_level", level[1], DEP - 1);
         finish_cycle();
      end
      set_in(3'b000, 0, 0, 0);
      repeat (5) step();

      // Flush in the middle of a reuse run, with an input beat offered.
      cfg_reuse = '{4'd0, 4'd0, 4'd3};
      set_in(3'b111, 700, 800, 900);
      step();
      set_in(3'b110, 0, 801, 901);
      step();
      set_in(3'b110, 0, 802, 902);
      step();
      flush = 1'b1;
      set_in(3'b111, 999, 999, 999);
      step();
      flush = 1'b0;
      set_in(3'b000, 0, 0, 0);
      @(negedge clk);
      chk("f_level0", level[0], 0);
      chk("f_valid", out_valid, 1'b0);
      chk("f_first", out_first, 1'b1);
      finish_cycle();
      @(negedge clk);
      chk("f_dropped", level, 0);
      finish_cycle();

      // Reuse count lowered below the current use count releases the head.
      cfg_reuse = '{4'd0, 4'd0, 4'd3};
      set_in(3'b111, 1000, 1100, 1200);
      step();
      set_in(3'b110, 0, 1101, 1201);
      step();
      set_in(3'b000, 0, 0, 0);
      step();
      step();
      cfg_reuse = '{4'd0, 4'd0, 4'd1};
      set_in(3'b110, 0, 1102, 1202);
      step();
      set_in(3'b000, 0, 0, 0);
      step();
      @(negedge clk);
      chk("ge_level0", level[0], 0);
      finish_cycle();

      // Randomized traffic with stalls and wraps, cleared by flush between phases.
      for (int ph = 0; ph < 3; ph++) begin
         flush = 1'b1;
         step();
         flush = 1'b0;
         for (int c = 0; c < NCH; c++) cfg_reuse[c] = 4'($urandom_range(0, 2));
         for (int i = 0; i < 120; i++) begin
            in_valid  = 3'($urandom);
            for (int c = 0; c < NCH; c++) in_vec[c] = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 9) < 7);
            step();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
